qam16_symbol_mapper: RTL and testbench
======================================

Name: qam16_symbol_mapper

Overview:
- Upstream feeder of the upsampler/FIR/output-storage chain.
- Accepts a byte stream over a valid/ready handshake and splits each byte into two 4-bit symbols, high nibble first.
- Gray-maps each symbol onto 16-QAM I/Q levels, presents them with a registered valid/ready output, and counts the emitted symbols.

Parameters:
- CNT_W, 16, width of the emitted-symbol counter (wraps modulo 2^CNT_W).
- LFSR_SEED, 15'h4A80, scrambler seed loaded at reset. Used only when QAM_SCRAMBLE_EN is defined.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  payload byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  mapper accepts byte_in this cycle.
- sym_nibble  output  4  raw (post-scramble) symbol, feeds upsampler data_in.
- sym_i  output  4  signed I level.
- sym_q  output  4  signed Q level.
- sym_valid  output  1  sym_* outputs are valid.
- sym_ready  input  1  downstream takes the symbol.
- sym_count  output  CNT_W  number of completed symbol handshakes.
- busy  output  1  high whenever state is not EMPTY.

Behaviour:
- Reset (rst=1 at an edge):
  - state=EMPTY.
  - sym_nibble, sym_i, sym_q, sym_count = 0; sym_valid = 0.
  - Internal low-nibble holding register = 0; LFSR = LFSR_SEED.
  - Reset overrides any handshake in the same cycle. A byte in flight is discarded.
- Handshakes:
  - Input accept = byte_valid & byte_ready.
  - Output transfer = sym_valid & sym_ready.
- FSM states:
  - EMPTY: no symbol held.
  - HI: high nibble presented.
  - LO: low nibble presented.
- byte_ready (combinational) = (state==EMPTY) | (state==LO & sym_ready). It never depends on byte_valid.
- Transitions:
  - EMPTY + accept -> HI. Output regs load byte_in[7:4]; byte_in[3:0] is stored.
  - HI + transfer -> LO. Output regs load the stored nibble.
  - HI, no transfer -> stay; outputs stable.
  - LO + transfer + accept -> HI with the new byte's high nibble. Zero-bubble: one symbol per cycle is sustained.
  - LO + transfer, no accept -> EMPTY; sym_valid=0.
  - LO, no transfer -> stay.
- Latency: byte accepted at edge k -> high-nibble symbol valid at edge k+1's cycle (1 cycle). Low nibble follows on the cycle after the high nibble's transfer.
- sym_valid = (state==HI | state==LO), registered. Outputs never change while sym_valid & !sym_ready.
- Mapping for nibble b3b2b1b0, 4-bit two's complement:
  - I from b3b2: 00 -> -3 (4'hD), 01 -> -1 (4'hF), 11 -> +1 (4'h1), 10 -> +3 (4'h3).
  - Q from b1b0: same mapping.
- sym_count increments by 1 on each transfer and wraps from all-ones to 0.
- byte_valid toggling while byte_ready=0 has no effect.

Optional Feature:
- Macro: QAM_SCRAMBLE_EN.
- Defined:
  - Additive scrambler, polynomial 1+x^14+x^15, 15-bit LFSR.
  - Each nibble loaded into the output regs is XORed with lfsr[14:11] before mapping; sym_nibble carries the scrambled value.
  - The LFSR then advances 4 steps in the same edge.
  - The LFSR advances only on nibble load, never on stall.
- Undefined: no LFSR; nibbles pass unmodified; LFSR_SEED unused.

Decomposition:
- Shared package qam_pkg:
  - State encoding (EMPTY=2'd0, HI=2'd1, LO=2'd2).
  - Gray level constants (LVL_M3, LVL_M1, LVL_P1, LVL_P3).
  - Scrambler polynomial taps and default seed.
- One sub-module: qam16_gray_lut. Purely combinational; 2 bits -> 4-bit signed level; instantiated twice (I and Q).

Test Plan:
- Reset, then byte 8'hB4 with sym_ready=1 -> symbols:
  - nibble 4'hB: I=+3, Q=+1.
  - Then 4'h4: I=-1, Q=-3.
  - sym_count=2, state returns EMPTY.
- Continuous bytes 8'h00, 8'hFF with sym_ready=1 -> 4 symbols on 4 consecutive cycles, no bubble:
  - 4'h0 twice (I=Q=-3).
  - 4'hF twice (I=Q=+1).
  - byte_ready high in the LO cycles.
- Hold sym_ready=0 for 5 cycles after 8'h3C is accepted -> sym_nibble=4'h3 stable, byte_ready=0 throughout. Release -> 4'hC next.
- Assert rst during LO with byte_valid=1 -> next cycle sym_valid=0, sym_count=0, byte_ready=1; the pending byte is not accepted.
- Preload counter path: 2^CNT_W transfers -> sym_count wraps to 0.
- With QAM_SCRAMBLE_EN: byte 8'h00 after reset -> first sym_nibble = LFSR_SEED[14:11] = 4'h9. The second nibble matches the golden LFSR model after 4 steps.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared definitions for the 16-QAM symbol mapper: FSM states, Gray levels and
// the 1+x^14+x^15 scrambler helper used when QAM_SCRAMBLE_EN is defined.
package qam_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } state_t;

    localparam logic [3:0] LVL_M3 = 4'hD;
    localparam logic [3:0] LVL_M1 = 4'hF;
    localparam logic [3:0] LVL_P1 = 4'h1;
    localparam logic [3:0] LVL_P3 = 4'h3;

    localparam int          SCR_TAP_HI       = 14;
    localparam int          SCR_TAP_LO       = 13;
    localparam logic [14:0] SCR_DEFAULT_SEED = 15'h4A80;

    // Four Fibonacci steps: feedback x^15 ^ x^14 shifts in at bit 0.
    function automatic logic [14:0] lfsr_advance4(input logic [14:0] s);
        logic [14:0] r;
        r = s;
        for (int k = 0; k < 4; k++) begin
            r = {r[13:0], r[SCR_TAP_HI] ^ r[SCR_TAP_LO]};
        end
        return r;
    endfunction

endpackage

// File: rtl/qam16_gray_lut.sv
// Two Gray-coded bits to a signed 16-QAM amplitude level (-3, -1, +1, +3).
module qam16_gray_lut
    import qam_pkg::*;
(
    input  logic [1:0] bits,
    output logic [3:0] level
);

    always_comb begin
        level = LVL_M3;
        case (bits)
            2'b00: level = LVL_M3;
            2'b01: level = LVL_M1;
            2'b11: level = LVL_P1;
            2'b10: level = LVL_P3;
            default: level = LVL_M3;
        endcase
    end

endmodule

// File: rtl/qam16_symbol_mapper.sv
// Byte-to-16-QAM symbol mapper, high nibble first, with a zero-bubble handshake.
// Optional additive scrambler enabled by defining QAM_SCRAMBLE_EN.
module qam16_symbol_mapper
    import qam_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [14:0] LFSR_SEED = SCR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [3:0]       sym_nibble,
    output logic [3:0]       sym_i,
    output logic [3:0]       sym_q,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] sym_count,
    output logic             busy
);

    state_t     state;
    logic [3:0] lo_hold;
    logic [3:0] raw_nib;
    logic [3:0] load_nib;
    logic [3:0] lvl_i;
    logic [3:0] lvl_q;
    logic       accept;
    logic       transfer;
    logic       load_en;

    assign byte_ready = (state == EMPTY) | ((state == LO) & sym_ready);
    assign accept     = byte_valid & byte_ready;
    assign transfer   = sym_valid & sym_ready;
    assign busy       = (state != EMPTY);

    // Only HI hands out the stored low nibble; every other load takes a fresh high nibble.
    assign raw_nib = (state == HI) ? lo_hold : byte_in[7:4];
    assign load_en = ((state == EMPTY) & accept)
                   | ((state == HI) & transfer)
                   | ((state == LO) & transfer & accept);

`ifdef QAM_SCRAMBLE_EN
    logic [14:0] lfsr;

    assign load_nib = raw_nib ^ lfsr[14:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (load_en) begin
            lfsr <= lfsr_advance4(lfsr);
        end
    end
`else
    logic unused_seed;

    assign load_nib    = raw_nib;
    assign unused_seed = ^LFSR_SEED;
`endif

    qam16_gray_lut u_lut_i (
        .bits  (load_nib[3:2]),
        .level (lvl_i)
    );

    qam16_gray_lut u_lut_q (
        .bits  (load_nib[1:0]),
        .level (lvl_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            lo_hold    <= 4'h0;
            sym_nibble <= 4'h0;
            sym_i      <= 4'h0;
            sym_q      <= 4'h0;
            sym_valid  <= 1'b0;
            sym_count  <= '0;
        end else begin
            if (load_en) begin
                sym_nibble <= load_nib;
                sym_i      <= lvl_i;
                sym_q      <= lvl_q;
            end
            if (transfer) begin
                sym_count <= sym_count + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= HI;
                        sym_valid <= 1'b1;
                        lo_hold   <= byte_in[3:0];
                    end
                end
                HI: begin
                    if (transfer) begin
                        state <= LO;
                    end
                end
                LO: begin
                    if (transfer) begin
                        if (accept) begin
                            state   <= HI;
                            lo_hold <= byte_in[3:0];
                        end else begin
                            state     <= EMPTY;
                            sym_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    sym_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Directed self-checking bench for qam16_symbol_mapper; the scrambled build
// (QAM_SCRAMBLE_EN) swaps the plain-nibble tests for a scrambler test.
module tb_qam16_symbol_mapper;

    localparam int TB_CNT_W = 10;

    logic                clk;
    logic                rst;
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic [3:0]          sym_nibble;
    logic [3:0]          sym_i;
    logic [3:0]          sym_q;
    logic                sym_valid;
    logic                sym_ready;
    logic [TB_CNT_W-1:0] sym_count;
    logic                busy;

    int checks;
    int failures;

    qam16_symbol_mapper #(
        .CNT_W     (TB_CNT_W),
        .LFSR_SEED (15'h4A80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sym_nibble (sym_nibble),
        .sym_i      (sym_i),
        .sym_q      (sym_q),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_count  (sym_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        sym_ready  = 1'b0;
        byte_in    = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", sym_valid); end
        checks++; if (sym_count !== '0) begin failures++; $display("[TB] FAIL reset_count actual=%h required=0", sym_count); end
        checks++; if ({sym_nibble, sym_i, sym_q} !== 12'h000) begin failures++; $display("[TB] FAIL reset_outputs actual=%h required=000", {sym_nibble, sym_i, sym_q}); end
        checks++; if ({byte_ready, busy} !== 2'b10) begin failures++; $display("[TB] FAIL reset_ready_busy actual=%b required=10", {byte_ready, busy}); end
    endtask

    task automatic test_single_byte();
        byte_in = 8'hB4; byte_valid = 1'b1; sym_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'hB31}) begin failures++; $display("[TB] FAIL single_hi actual=%b_%h%h%h required=1_B31", sym_valid, sym_nibble, sym_i, sym_q); end
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_hi_ready actual=%b required=0", byte_ready); end
        step();
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h4FD}) begin failures++; $display("[TB] FAIL single_lo actual=%b_%h%h%h required=1_4FD", sym_valid, sym_nibble, sym_i, sym_q); end
        checks++; if (sym_count !== TB_CNT_W'(1)) begin failures++; $display("[TB] FAIL single_lo_count actual=%0d required=1", sym_count); end
        step();
        checks++; if ({sym_valid, busy} !== 2'b00) begin failures++; $display("[TB] FAIL single_empty actual=%b required=00", {sym_valid, busy}); end
        checks++; if (sym_count !== TB_CNT_W'(2)) begin failures++; $display("[TB] FAIL single_count actual=%0d required=2", sym_count); end
    endtask

    task automatic test_back_to_back();
        byte_in = 8'h00; byte_valid = 1'b1; sym_ready = 1'b1;
        step();
        byte_in = 8'hFF;
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h0DD}) begin failures++; $display("[TB] FAIL b2b_sym0 actual=%b_%h%h%h required=1_0DD", sym_valid, sym_nibble, sym_i, sym_q); end
        step();
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h0DD}) begin failures++; $display("[TB] FAIL b2b_sym1 actual=%b_%h%h%h required=1_0DD", sym_valid, sym_nibble, sym_i, sym_q); end
        checks++; if (byte_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_lo_ready actual=%b required=1", byte_ready); end
        step();
        byte_valid = 1'b0;
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'hF11}) begin failures++; $display("[TB] FAIL b2b_sym2 actual=%b_%h%h%h required=1_F11", sym_valid, sym_nibble, sym_i, sym_q); end
        step();
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'hF11}) begin failures++; $display("[TB] FAIL b2b_sym3 actual=%b_%h%h%h required=1_F11", sym_valid, sym_nibble, sym_i, sym_q); end
        checks++; if (byte_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_lo_ready2 actual=%b required=1", byte_ready); end
        step();
        checks++; if ({sym_valid, sym_count} !== {1'b0, TB_CNT_W'(6)}) begin failures++; $display("[TB] FAIL b2b_end actual=%b_%0d required=0_6", sym_valid, sym_count); end
    endtask

    task automatic test_stall();
        byte_in = 8'h3C; byte_valid = 1'b1; sym_ready = 1'b0;
        step();
        byte_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h3D1}) begin failures++; $display("[TB] FAIL stall_hold_%0d actual=%b_%h%h%h required=1_3D1", c, sym_valid, sym_nibble, sym_i, sym_q); end
            checks++; if ({byte_ready, sym_count} !== {1'b0, TB_CNT_W'(6)}) begin failures++; $display("[TB] FAIL stall_ready_%0d actual=%b_%0d required=0_6", c, byte_ready, sym_count); end
            byte_valid = ~byte_valid;
            byte_in    = 8'hA5;
            step();
        end
        byte_valid = 1'b0; sym_ready = 1'b1;
        step();
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'hC1D}) begin failures++; $display("[TB] FAIL stall_release actual=%b_%h%h%h required=1_C1D", sym_valid, sym_nibble, sym_i, sym_q); end
        step();
        checks++; if ({sym_valid, sym_count} !== {1'b0, TB_CNT_W'(8)}) begin failures++; $display("[TB] FAIL stall_end actual=%b_%0d required=0_8", sym_valid, sym_count); end
    endtask

    task automatic test_reset_in_lo();
        byte_in = 8'h5A; byte_valid = 1'b1; sym_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        step();
        checks++; if ({sym_valid, byte_ready} !== 2'b11) begin failures++; $display("[TB] FAIL rstlo_in_lo actual=%b required=11", {sym_valid, byte_ready}); end
        byte_in = 8'h77; byte_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({sym_valid, byte_ready, busy} !== 3'b010) begin failures++; $display("[TB] FAIL rstlo_flags actual=%b required=010", {sym_valid, byte_ready, busy}); end
        checks++; if ({sym_count, sym_nibble} !== {TB_CNT_W'(0), 4'h0}) begin failures++; $display("[TB] FAIL rstlo_regs actual=%0d_%h required=0_0", sym_count, sym_nibble); end
        byte_valid = 1'b0;
        step();
        checks++; if ({sym_valid, busy} !== 2'b00) begin failures++; $display("[TB] FAIL rstlo_no_accept actual=%b required=00", {sym_valid, busy}); end
    endtask

    task automatic test_wrap();
        do_reset();
        byte_in = 8'h96; byte_valid = 1'b1; sym_ready = 1'b1;
        step();
        repeat ((1 << TB_CNT_W) - 1) step();
        checks++; if (sym_count !== {TB_CNT_W{1'b1}}) begin failures++; $display("[TB] FAIL wrap_all_ones actual=%h required=%h", sym_count, {TB_CNT_W{1'b1}}); end
        step();
        checks++; if ({sym_valid, sym_count} !== {1'b1, TB_CNT_W'(0)}) begin failures++; $display("[TB] FAIL wrap_zero actual=%b_%h required=1_0", sym_valid, sym_count); end
        byte_valid = 1'b0;
        step();
        step();
        checks++; if ({sym_valid, sym_count} !== {1'b0, TB_CNT_W'(2)}) begin failures++; $display("[TB] FAIL wrap_drain actual=%b_%0d required=0_2", sym_valid, sym_count); end
    endtask

    // Seed 4A80: first mask seed[14:11]=9; after four shifts the mask is seed[10:7]=5.
    task automatic test_scramble();
        do_reset();
        byte_in = 8'h00; byte_valid = 1'b1; sym_ready = 1'b0;
        step();
        byte_valid = 1'b0;
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h93F}) begin failures++; $display("[TB] FAIL scr_first actual=%b_%h%h%h required=1_93F", sym_valid, sym_nibble, sym_i, sym_q); end
        step();
        step();
        checks++; if (sym_nibble !== 4'h9) begin failures++; $display("[TB] FAIL scr_stall actual=%h required=9", sym_nibble); end
        sym_ready = 1'b1;
        step();
        checks++; if ({sym_valid, sym_nibble, sym_i, sym_q} !== {1'b1, 12'h5FF}) begin failures++; $display("[TB] FAIL scr_second actual=%b_%h%h%h required=1_5FF", sym_valid, sym_nibble, sym_i, sym_q); end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sym_ready  = 1'b0;
        test_reset();
`ifdef QAM_SCRAMBLE_EN
        test_scramble();
`else
        test_single_byte();
        test_back_to_back();
        test_stall();
`endif
        test_reset_in_lo();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
